// File: rtl/counter_value_fifo.sv
// -----------------------------------------------------------------------------
// counter_value_fifo
//
// Purpose:
//   Small synchronous FIFO that stores snapshots of the up/down counter value.
//   Pushes and pops are requested by button press detectors using a level
//   request / one-cycle ack handshake. Each request is serviced exactly once:
//   a request is serviced on an edge where the request is high and its ack is
//   low, and the registered ack pulse then masks the still-high request on the
//   following edge while the requester drops it.
//
// Handshake (push and pop are identical):
//   A request is serviced at a rising edge where req=1 and ack=0. The ack is
//   high for exactly the cycle after the servicing edge. While the ack is high,
//   the request is ignored, so at most one service happens every two cycles.
//
// Ports:
//   clock      in   1             rising-edge clock (debouncing clock)
//   reset      in   1             synchronous, active-high reset
//   pushReq    in   1             level push request
//   pushAck    out  1             one-cycle pulse, push serviced
//   popReq     in   1             level pop request
//   popAck     out  1             one-cycle pulse, pop serviced
//   dataIn     in   WIDTH         value stored on a serviced push
//   dataOut    out  WIDTH         head entry, 0 when empty
//   count      out  DEPTH_BITS+1  number of stored entries
//   empty      out  1             count == 0
//   full       out  1             count == 2**DEPTH_BITS
//   overflow   out  1             sticky, push serviced while full
//   underflow  out  1             sticky, pop serviced while empty
// -----------------------------------------------------------------------------
module counter_value_fifo #(
   parameter int WIDTH      = 4,
   parameter int DEPTH_BITS = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pushReq,
   output logic                  pushAck,
   input  logic                  popReq,
   output logic                  popAck,
   input  logic [WIDTH-1:0]      dataIn,
   output logic [WIDTH-1:0]      dataOut,
   output logic [DEPTH_BITS:0]   count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS + 1)'(DEPTH);
   localparam logic [DEPTH_BITS:0]   CNT_ONE  = 1;
   localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;

   // Storage and registered state
   logic [WIDTH-1:0]      r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] r_wr_ptr;
   logic [DEPTH_BITS-1:0] r_rd_ptr;
   logic [DEPTH_BITS:0]   r_count;
   logic                  r_push_ack;
   logic                  r_pop_ack;
   logic                  r_overflow;
   logic                  r_underflow;

   // Decoded service decisions
   logic w_push_svc;
   logic w_pop_svc;
   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;
   logic w_overflow_evt;
   logic w_underflow_evt;

   // A request is serviced only when its ack is low; the high ack cycle
   // hides the request the requester is in the middle of dropping.
   assign w_push_svc = pushReq & ~r_push_ack;
   assign w_pop_svc  = popReq  & ~r_pop_ack;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_FULL);

   // A pop on an empty FIFO does nothing but flag underflow. A push on a full
   // FIFO is still performed if a real pop in the same edge frees the head
   // entry, which is exactly the entry the write pointer addresses.
   assign w_do_pop        = w_pop_svc & ~w_empty;
   assign w_do_push       = w_push_svc & (~w_full | w_do_pop);
   assign w_overflow_evt  = w_push_svc & w_full & ~w_do_pop;
   assign w_underflow_evt = w_pop_svc & w_empty;

   // Control state
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_push_ack  <= 1'b0;
         r_pop_ack   <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_push_ack <= w_push_svc;
         r_pop_ack  <= w_pop_svc;

         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_ONE;
         end

         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase

         if (w_overflow_evt) begin
            r_overflow <= 1'b1;
         end
         if (w_underflow_evt) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Data storage carries no reset; dataOut is masked while empty, so stale
   // contents are never visible.
   always_ff @(posedge clock) begin
      if (!reset && w_do_push) begin
         r_mem[r_wr_ptr] <= dataIn;
      end
   end

   // Outputs: registered state or decoded from registered state only
   assign dataOut   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign count     = r_count;
   assign empty     = w_empty;
   assign full      = w_full;
   assign pushAck   = r_push_ack;
   assign popAck    = r_pop_ack;
   assign overflow  = r_overflow;
   assign underflow = r_underflow;

endmodule

// File: tb/tb_counter_value_fifo.sv
// -----------------------------------------------------------------------------
// tb_counter_value_fifo
//
// Drives request/ack handshakes into counter_value_fifo and keeps a queue
// model of the FIFO contents. Each issued pop pushes its expected popped value
// onto exp_q; a monitor pops exp_q whenever popAck is seen and compares it to
// the dataOut that was shown before the servicing edge.
// -----------------------------------------------------------------------------
module tb_counter_value_fifo;

  localparam int W     = 4;
  localparam int DB    = 2;
  localparam int DEPTH = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          pushReq = 1'b0;
  logic          popReq  = 1'b0;
  logic [W-1:0]  dataIn  = '0;
  logic          pushAck;
  logic          popAck;
  logic [W-1:0]  dataOut;
  logic [DB:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  counter_value_fifo #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .pushReq   (pushReq),
    .pushAck   (pushAck),
    .popReq    (popReq),
    .popAck    (popAck),
    .dataIn    (dataIn),
    .dataOut   (dataOut),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  // ---------------------------------------------------------------- bookkeeping
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------- reference model
  logic [W-1:0] model_q[$];
  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0;
  logic         m_unf = 1'b0;

  // Pop is applied first: an empty pop is an underflow even if a push comes
  // in the same cycle, and a pop on a full FIFO makes room for the push.
  task automatic model_apply(input bit do_push, input bit do_pop, input logic [W-1:0] v);
    if (do_pop) begin
      if (model_q.size() > 0) exp_q.push_back(model_q.pop_front());
      else begin
        exp_q.push_back('0);
        m_unf = 1'b1;
      end
    end
    if (do_push) begin
      if (model_q.size() < DEPTH) model_q.push_back(v);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    logic [W-1:0] head;
    head = (model_q.size() > 0) ? model_q[0] : '0;
    check({tag, ".count"},     32'(count),     32'(model_q.size()));
    check({tag, ".empty"},     32'(empty),     32'(model_q.size() == 0));
    check({tag, ".full"},      32'(full),      32'(model_q.size() == DEPTH));
    check({tag, ".dataOut"},   32'(dataOut),   32'(head));
    check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // ---------------------------------------------------------------- monitor
  logic [W-1:0] prev_dout     = '0;
  logic         prev_push_ack = 1'b0;
  logic         prev_pop_ack  = 1'b0;

  always @(negedge clock) begin
    if (popAck) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_popAck: got popAck=1 expected no pop outstanding at %0t", $time);
      end else begin
        check("pop_data", 32'(prev_dout), 32'(exp_q.pop_front()));
      end
    end
    if (pushAck && prev_push_ack) check("pushAck_width", 32'(2), 32'(1));
    if (popAck && prev_pop_ack)   check("popAck_width",  32'(2), 32'(1));
    prev_push_ack = pushAck;
    prev_pop_ack  = popAck;
    prev_dout     = dataOut;
  end

  // ---------------------------------------------------------------- drivers
  // Called at a negedge; returns at a negedge with requests low and acks low.
  task automatic handshake(input bit do_push, input bit do_pop, input logic [W-1:0] v, input string tag);
    bit got;
    model_apply(do_push, do_pop, v);
    pushReq = do_push;
    popReq  = do_pop;
    dataIn  = v;
    got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if ((!do_push || pushAck) && (!do_pop || popAck)) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check({tag, ".ack_timeout"}, 32'(0), 32'(1));
    pushReq = 1'b0;
    popReq  = 1'b0;
    check_state(tag);
    @(negedge clock);
    check({tag, ".acks_low"}, 32'({pushAck, popAck}), 32'(0));
  endtask

  task automatic do_reset(input bit hold_reqs);
    @(negedge clock);
    reset   = 1'b1;
    pushReq = hold_reqs;
    popReq  = hold_reqs;
    repeat (2) @(negedge clock);
    model_q.delete();
    exp_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_state("reset");
    check("reset.acks", 32'({pushAck, popAck}), 32'(0));
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [W-1:0] v;
    int op;

    // Reset with both requests held: they are serviced right after reset,
    // which is the empty simultaneous push 5 + pop case.
    do_reset(1'b1);
    handshake(1'b1, 1'b1, 4'd5, "post_reset_both");
    check("post_reset.dataOut", 32'(dataOut), 32'(5));

    // Push 3, 7, A then pop three times
    do_reset(1'b0);
    handshake(1'b1, 1'b0, 4'd3,  "push3");
    handshake(1'b1, 1'b0, 4'd7,  "push7");
    handshake(1'b1, 1'b0, 4'hA,  "pushA");
    handshake(1'b0, 1'b1, 4'd0,  "pop1");
    handshake(1'b0, 1'b1, 4'd0,  "pop2");
    handshake(1'b0, 1'b1, 4'd0,  "pop3");

    // Non-compliant requester holding pushReq for 5 cycles
    pushReq = 1'b1;
    dataIn  = 4'd5;
    repeat (5) @(negedge clock);
    pushReq = 1'b0;
    repeat (3) model_apply(1'b1, 1'b0, 4'd5);
    check_state("held_push");
    @(negedge clock);
    repeat (3) handshake(1'b0, 1'b1, 4'd0, "drain_held");

    // Fill, overflow, drain
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) handshake(1'b1, 1'b0, W'(i), "fill");
    handshake(1'b1, 1'b0, 4'd9, "overflow_push");
    for (int i = 0; i < 4; i++) handshake(1'b0, 1'b1, 4'd0, "drain_full");

    // Underflow
    handshake(1'b0, 1'b1, 4'd0, "underflow_pop");

    // Full with head=1, simultaneous push 6 and pop
    do_reset(1'b0);
    for (int i = 1; i <= 4; i++) handshake(1'b1, 1'b0, W'(i), "fill2");
    handshake(1'b1, 1'b1, 4'd6, "full_both");
    check("full_both.dataOut", 32'(dataOut), 32'(2));
    for (int i = 0; i < 4; i++) handshake(1'b0, 1'b1, 4'd0, "drain2");

    // Pointer wrap: 10 push/pop pairs
    do_reset(1'b0);
    handshake(1'b1, 1'b0, 4'hF, "wrap_pre");
    for (int i = 0; i < 10; i++) begin
      v = W'($urandom_range(0, 15));
      handshake(1'b1, 1'b0, v, "wrap_push");
      handshake(1'b0, 1'b1, 4'd0, "wrap_pop");
    end

    // Randomized mix
    do_reset(1'b0);
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 2);
      v  = W'($urandom_range(0, 15));
      handshake(op != 1, op != 0, v, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Drain whatever is left and confirm the monitor consumed all pops
    while (model_q.size() > 0) handshake(1'b0, 1'b1, 4'd0, "final_drain");
    repeat (2) @(negedge clock);
    check("exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
